mux157_byte_sequencer: RTL and testbench



---
 rtl/mux157_seq_pkg.sv | 19 +
 rtl/mux157_byte_sequencer_settle_timer.sv | 28 ++
 rtl/mux157_byte_sequencer.sv | 98 +++++++++
 tb/tb_mux157_byte_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux157_seq_pkg.sv
// Shared types and constants for the ic74x157 byte sequencer.
// Drive encodings follow the mux pins: port1 select, port15 active-low strobe.
package mux157_seq_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LO    = 2'd2,
        HI    = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    localparam logic G_ON  = 1'b0;
    localparam logic G_OFF = 1'b1;

endpackage

// File: rtl/mux157_byte_sequencer_settle_timer.sv
// Loadable down-counter that paces each sequencer phase.
// tc is high while the count sits at zero; the counter parks there until reloaded.
module settle_timer
    import mux157_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               tc
);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/mux157_byte_sequencer.sv
// Drives the ic74x157 select/strobe, waits out the settle time per phase and
// assembles the two sampled nibbles into a byte; also a local byte incrementer.
module mux157_byte_sequencer
    import mux157_seq_pkg::*;
#(
    parameter int SETTLE      = 1,
    parameter bit BLANK_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inc,
    input  logic [3:0] mux_y,
    output logic       mux_sel,
    output logic       mux_g_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] data,
    output logic       blank_err
);

    localparam logic [TIMER_W-1:0] SETTLE_CNT = TIMER_W'(SETTLE);

    state_t     state;
    logic [3:0] lo;
    logic       tc;
    logic       timer_load;

    // Reload on acceptance and on every phase change that enters another timed phase.
    assign timer_load = ((state == IDLE) && start) ||
                        (((state == BLANK) || (state == LO)) && tc);

    settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_CNT),
        .tc       (tc)
    );

    // NOTE: every register, including the data and nibble holders, has a defined reset value
    // so an aborted fetch never leaves a partial byte behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mux_g_n   <= G_OFF;
            mux_sel   <= SEL_A;
            busy      <= 1'b0;
            done      <= 1'b0;
            data      <= 8'h00;
            blank_err <= 1'b0;
            lo        <= 4'h0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BLANK;
                        busy      <= 1'b1;
                        blank_err <= 1'b0;
                        mux_g_n   <= G_OFF;
                        mux_sel   <= SEL_A;
                    end else if (inc) begin
                        data <= data + 8'd1;
                    end
                end
                BLANK: begin
                    if (tc) begin
                        if (BLANK_CHECK && (mux_y != 4'h0)) begin
                            blank_err <= 1'b1;
                        end
                        state   <= LO;
                        mux_g_n <= G_ON;
                        mux_sel <= SEL_A;
                    end
                end
                LO: begin
                    if (tc) begin
                        lo      <= mux_y;
                        state   <= HI;
                        mux_sel <= SEL_B;
                    end
                end
                HI: begin
                    if (tc) begin
                        data    <= {mux_y, lo};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        mux_g_n <= G_OFF;
                        mux_sel <= SEL_A;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux157_byte_sequencer.sv
// Scoreboarded bench: three sequencer instances (SETTLE 1, 0, 15), each behind a
// behavioural 74x157 model; expected bytes are queued at start and popped on done.
module tb_mux157_byte_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_v [3];
    logic       inc_v   [3];
    logic       sel_v   [3];
    logic       g_n_v   [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       berr_v  [3];
    logic [7:0] data_v  [3];
    logic [3:0] a_v     [3];
    logic [3:0] b_v     [3];
    logic [3:0] blank_v [3];
    logic [3:0] y_v     [3];

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Mux model: strobe off shows the injected blank value (0 on a healthy board).
    for (genvar g = 0; g < 3; g++) begin : g_mux
        assign y_v[g] = g_n_v[g] ? blank_v[g] : (sel_v[g] ? b_v[g] : a_v[g]);
    end

    mux157_byte_sequencer #(.SETTLE(1), .BLANK_CHECK(1'b1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .inc(inc_v[0]), .mux_y(y_v[0]),
        .mux_sel(sel_v[0]), .mux_g_n(g_n_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .data(data_v[0]), .blank_err(berr_v[0]));

    mux157_byte_sequencer #(.SETTLE(0), .BLANK_CHECK(1'b1)) dut_s0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .inc(inc_v[1]), .mux_y(y_v[1]),
        .mux_sel(sel_v[1]), .mux_g_n(g_n_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .data(data_v[1]), .blank_err(berr_v[1]));

    mux157_byte_sequencer #(.SETTLE(15), .BLANK_CHECK(1'b0)) dut_s15 (
        .clk(clk), .rst(rst), .start(start_v[2]), .inc(inc_v[2]), .mux_y(y_v[2]),
        .mux_sel(sel_v[2]), .mux_g_n(g_n_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .data(data_v[2]), .blank_err(berr_v[2]));

    function automatic int settle_of(int id);
        return (id == 0) ? 1 : ((id == 1) ? 0 : 15);
    endfunction

    function automatic void sb_push(int id, logic [7:0] v);
        case (id)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic bit sb_pop(int id, output logic [7:0] v);
        v = 8'h00;
        sb_pop = 1'b0;
        case (id)
            0:       if (q0.size() > 0) begin v = q0.pop_front(); sb_pop = 1'b1; end
            1:       if (q1.size() > 0) begin v = q1.pop_front(); sb_pop = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); sb_pop = 1'b1; end
        endcase
    endfunction

    // Scoreboard monitor: every done must match the oldest outstanding fetch.
    always @(negedge clk) begin
        logic [7:0] e;
        bit         ok;
        for (int i = 0; i < 3; i++) begin
            if (!rst && done_v[i] === 1'b1) begin
                ok = sb_pop(i, e);
                n_checks++;
                if (!ok)
                    $display("FAIL sb_unexpected_done dut%0d: data=%02h with no fetch outstanding", i, data_v[i]);
                else if (data_v[i] !== e)
                    $display("FAIL sb_data dut%0d: got %02h expected %02h", i, data_v[i], e);
                else
                    n_pass++;
            end
        end
    end

    // One complete fetch with per-cycle checks of busy, mux drive and held data.
    task automatic run_fetch(int id, logic [3:0] a, logic [3:0] b, logic [3:0] blank, logic with_inc);
        int         s;
        int         lat;
        int         cyc;
        int         ph;
        logic       exp_g;
        logic       exp_sel;
        logic [7:0] held;
        s   = settle_of(id);
        lat = 3 * (s + 1);
        a_v[id]     = a;
        b_v[id]     = b;
        blank_v[id] = blank;
        @(negedge clk);
        held        = data_v[id];
        start_v[id] = 1'b1;
        inc_v[id]   = with_inc;
        sb_push(id, {b, a});
        @(negedge clk);
        start_v[id] = 1'b0;
        inc_v[id]   = 1'b0;
        cyc = 0;
        while (done_v[id] !== 1'b1 && cyc < lat + 4) begin
            ph      = cyc / (s + 1);
            exp_g   = (ph == 0);
            exp_sel = (ph == 2);
            n_checks++;
            if ({busy_v[id], g_n_v[id], sel_v[id], data_v[id]} !== {1'b1, exp_g, exp_sel, held})
                $display("FAIL fetch_cycle dut%0d cyc%0d: busy/g_n/sel/data=%b/%b/%b/%02h expected 1/%b/%b/%02h",
                         id, cyc, busy_v[id], g_n_v[id], sel_v[id], data_v[id], exp_g, exp_sel, held);
            else
                n_pass++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== lat)
            $display("FAIL latency dut%0d: got %0d cycles expected %0d", id, cyc, lat);
        else
            n_pass++;
        n_checks++;
        if ({busy_v[id], g_n_v[id], sel_v[id]} !== 3'b010)
            $display("FAIL commit_drive dut%0d: busy/g_n/sel=%b%b%b expected 010", id, busy_v[id], g_n_v[id], sel_v[id]);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done_v[id], busy_v[id], data_v[id]} !== {2'b00, b, a})
            $display("FAIL done_width dut%0d: done/busy/data=%b/%b/%02h expected 0/0/%02h",
                     id, done_v[id], busy_v[id], data_v[id], {b, a});
        else
            n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({g_n_v[i], sel_v[i], busy_v[i], done_v[i], data_v[i], berr_v[i]} !== {4'b1000, 8'h00, 1'b0})
                $display("FAIL reset_values dut%0d: g_n/sel/busy/done/data/err=%b/%b/%b/%b/%02h/%b expected 1/0/0/0/00/0",
                         i, g_n_v[i], sel_v[i], busy_v[i], done_v[i], data_v[i], berr_v[i]);
            else
                n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_fetch(0, 4'h5, 4'hA, 4'h0, 1'b0);
        n_checks++;
        if (berr_v[0] !== 1'b0) $display("FAIL basic_blank_err: got %b expected 0", berr_v[0]);
        else n_pass++;
    endtask

    task automatic test_inc();
        run_fetch(0, 4'hF, 4'hF, 4'h0, 1'b0);
        @(negedge clk);
        inc_v[0] = 1'b1;
        @(negedge clk);
        inc_v[0] = 1'b0;
        n_checks++;
        if ({data_v[0], done_v[0], busy_v[0]} !== {8'h00, 2'b00})
            $display("FAIL inc_wrap: data/done/busy=%02h/%b/%b expected 00/0/0", data_v[0], done_v[0], busy_v[0]);
        else
            n_pass++;
        // start and inc together: data must hold 00 through the fetch, then commit 63.
        run_fetch(0, 4'h3, 4'h6, 4'h0, 1'b1);
    endtask

    task automatic test_blank();
        run_fetch(0, 4'h1, 4'h2, 4'h3, 1'b0);
        n_checks++;
        if (berr_v[0] !== 1'b1) $display("FAIL blank_fault_set: got %b expected 1", berr_v[0]);
        else n_pass++;
        run_fetch(0, 4'h4, 4'h5, 4'h0, 1'b0);
        n_checks++;
        if (berr_v[0] !== 1'b0) $display("FAIL blank_fault_clear: got %b expected 0", berr_v[0]);
        else n_pass++;
        run_fetch(2, 4'h7, 4'h8, 4'h9, 1'b0);
        n_checks++;
        if (berr_v[2] !== 1'b0) $display("FAIL blank_check_off: got %b expected 0", berr_v[2]);
        else n_pass++;
    endtask

    task automatic test_busy_reject();
        int nd;
        nd = 0;
        a_v[0] = 4'h6;
        b_v[0] = 4'h9;
        blank_v[0] = 4'h0;
        @(negedge clk);
        start_v[0] = 1'b1;
        sb_push(0, 8'h96);
        @(negedge clk);
        // Re-pulse start and inc while the FSM is in LO (c=2) and HI (c=4).
        for (int c = 0; c < 12; c++) begin
            if (done_v[0] === 1'b1) nd++;
            start_v[0] = (c == 2 || c == 4);
            inc_v[0]   = (c == 2 || c == 4);
            @(negedge clk);
        end
        n_checks++;
        if ({nd, data_v[0]} !== {32'd1, 8'h96})
            $display("FAIL busy_reject: dones=%0d data=%02h expected 1 and 96", nd, data_v[0]);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int w;
        int p;
        a_v[0] = 4'h1;
        b_v[0] = 4'hE;
        @(negedge clk);
        start_v[0] = 1'b1;
        sb_push(0, 8'hE1);
        @(negedge clk);
        start_v[0] = 1'b0;
        w = 0;
        while (done_v[0] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        start_v[0] = 1'b1;
        a_v[0] = 4'h7;
        b_v[0] = 4'h3;
        sb_push(0, 8'h37);
        @(negedge clk);
        start_v[0] = 1'b0;
        p = 1;
        while (done_v[0] !== 1'b1 && p < 20) begin
            @(negedge clk);
            p++;
        end
        n_checks++;
        if (p !== 7) $display("FAIL back_to_back_period: got %0d cycles expected 7", p);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch();
        a_v[0] = 4'hC;
        b_v[0] = 4'hD;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({g_n_v[0], sel_v[0], busy_v[0], done_v[0], data_v[0], berr_v[0]} !== {4'b1000, 8'h00, 1'b0})
            $display("FAIL async_reset_hi: g_n/sel/busy/done/data/err=%b/%b/%b/%b/%02h/%b expected 1/0/0/0/00/0",
                     g_n_v[0], sel_v[0], busy_v[0], done_v[0], data_v[0], berr_v[0]);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_v[0], g_n_v[0], data_v[0]} !== {2'b01, 8'h00})
            $display("FAIL no_resume: busy/g_n/data=%b/%b/%02h expected 0/1/00", busy_v[0], g_n_v[0], data_v[0]);
        else
            n_pass++;
        run_fetch(0, 4'h1, 4'h2, 4'h0, 1'b0);
    endtask

    task automatic test_settle_extremes();
        run_fetch(1, 4'hA, 4'h5, 4'h0, 1'b0);
        run_fetch(1, 4'h0, 4'hF, 4'h0, 1'b0);
        run_fetch(2, 4'hB, 4'hC, 4'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            inc_v[i]   = 1'b0;
            a_v[i]     = 4'h0;
            b_v[i]     = 4'h0;
            blank_v[i] = 4'h0;
        end
        test_reset();
        test_basic();
        test_inc();
        test_blank();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid_fetch();
        test_settle_extremes();
        repeat (2) @(negedge clk);
        n_checks++;
        if (q0.size() + q1.size() + q2.size() != 0)
            $display("FAIL sb_drain: %0d/%0d/%0d fetches never completed expected 0/0/0", q0.size(), q1.size(), q2.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
